// File: rtl/mfp_ahb_input_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mfp_ahb_input_reader                                                     |
// | AHB-Lite slave: debounced switches/buttons, sticky press flags, IRQ.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mfp_ahb_input_reader #(
  parameter int NSW             = 16,
  parameter int NBTN            = 5,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic [3:0]      HADDR,
  input  logic [1:0]      HTRANS,
  input  logic            HWRITE,
  input  logic            HSEL,
  input  logic [31:0]     HWDATA,
  output logic [31:0]     HRDATA,
  input  logic [NSW-1:0]  IO_SW,
  input  logic [NBTN-1:0] IO_PB,
  output logic            IO_PB_IRQ
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  localparam logic [3:0] c_idx_sw   = 4'd0;
  localparam logic [3:0] c_idx_pb   = 4'd1;
  localparam logic [3:0] c_idx_evt  = 4'd2;
  localparam logic [3:0] c_idx_mask = 4'd3;

  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;

  logic [NSW-1:0]  r_sw_meta, r_sw_sync, r_sw_samp, r_sw_stable;
  logic [NBTN-1:0] r_pb_meta, r_pb_sync, r_pb_samp, r_pb_stable;
  logic [NBTN-1:0] r_pb_stable_d, r_pb_rise;
  logic [NBTN-1:0] r_pb_evt, r_pb_mask;
  logic            r_irq;

  logic            r_dp_valid;
  logic            r_write;
  logic [3:0]      r_addr;

  logic [NSW-1:0]  w_sw_eq;
  logic [NBTN-1:0] w_pb_eq;
  logic            w_wr;
  logic [NBTN-1:0] w_evt_clr;
  logic [31:0]     w_rdata;
  logic            w_unused;

  assign w_tick = (r_cnt == c_cnt_max);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cnt_one;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_pb_meta <= '0;
      r_pb_sync <= '0;
    end else begin
      r_sw_meta <= IO_SW;
      r_sw_sync <= r_sw_meta;
      r_pb_meta <= IO_PB;
      r_pb_sync <= r_pb_meta;
    end
  end

  // A bit propagates to stable only when it matches at two consecutive ticks.
  assign w_sw_eq = ~(r_sw_sync ^ r_sw_samp);
  assign w_pb_eq = ~(r_pb_sync ^ r_pb_samp);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sw_samp   <= '0;
      r_sw_stable <= '0;
      r_pb_samp   <= '0;
      r_pb_stable <= '0;
    end else if (w_tick) begin
      r_sw_samp   <= r_sw_sync;
      r_sw_stable <= (r_sw_stable & ~w_sw_eq) | (r_sw_sync & w_sw_eq);
      r_pb_samp   <= r_pb_sync;
      r_pb_stable <= (r_pb_stable & ~w_pb_eq) | (r_pb_sync & w_pb_eq);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dp_valid <= 1'b0;
      r_write    <= 1'b0;
      r_addr     <= '0;
    end else begin
      r_dp_valid <= HSEL & HTRANS[1];
      if (HSEL && HTRANS[1]) begin
        r_write <= HWRITE;
        r_addr  <= HADDR;
      end
    end
  end

  assign w_wr      = r_dp_valid & r_write;
  assign w_evt_clr = (w_wr && (r_addr == c_idx_evt)) ? HWDATA[NBTN-1:0] : '0;

  // Set is applied after the clear so a coincident press is never lost.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pb_stable_d <= '0;
      r_pb_rise     <= '0;
      r_pb_evt      <= '0;
      r_pb_mask     <= '0;
      r_irq         <= 1'b0;
    end else begin
      r_pb_stable_d <= r_pb_stable;
      r_pb_rise     <= r_pb_stable & ~r_pb_stable_d;
      r_pb_evt      <= (r_pb_evt & ~w_evt_clr) | r_pb_rise;
      if (w_wr && (r_addr == c_idx_mask)) begin
        r_pb_mask <= HWDATA[NBTN-1:0];
      end
      r_irq <= |(r_pb_evt & r_pb_mask);
    end
  end

  always_comb begin
    w_rdata = '0;
    if (r_dp_valid && !r_write) begin
      case (r_addr)
        c_idx_sw:   w_rdata[NSW-1:0]  = r_sw_stable;
        c_idx_pb:   w_rdata[NBTN-1:0] = r_pb_stable;
        c_idx_evt:  w_rdata[NBTN-1:0] = r_pb_evt;
        c_idx_mask: w_rdata[NBTN-1:0] = r_pb_mask;
        default:    w_rdata = '0;
      endcase
    end
  end

  assign HRDATA    = w_rdata;
  assign IO_PB_IRQ = r_irq;
  assign w_unused  = ^{HWDATA, HTRANS[0]};

endmodule
`default_nettype wire

// File: tb/tb_mfp_ahb_input_reader.sv
`default_nettype none
// Bench for mfp_ahb_input_reader: directed scenarios plus random traffic,
// all checked cycle by cycle against a rule-level model of the register map.
module tb_mfp_ahb_input_reader;
  localparam int NSW  = 16;
  localparam int NBTN = 5;
  localparam int D    = 4;

  logic            HCLK = 1'b0;
  logic            HRESETn = 1'b0;
  logic [3:0]      HADDR = '0;
  logic [1:0]      HTRANS = '0;
  logic            HWRITE = 1'b0;
  logic            HSEL = 1'b0;
  logic [31:0]     HWDATA = '0;
  logic [31:0]     HRDATA;
  logic [NSW-1:0]  IO_SW = '0;
  logic [NBTN-1:0] IO_PB = '0;
  logic            IO_PB_IRQ;

  int tests = 0;
  int fails = 0;

  mfp_ahb_input_reader #(.NSW(NSW), .NBTN(NBTN), .DEBOUNCE_CYCLES(D)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSEL(HSEL), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .IO_SW(IO_SW), .IO_PB(IO_PB), .IO_PB_IRQ(IO_PB_IRQ)
  );

  always #5 HCLK = ~HCLK;

  // Model state: pin history, debounce samples, stable levels and registers.
  logic [NSW-1:0]  m_sw_meta = '0, m_sw_sync = '0, m_sw_samp = '0, m_sw_st = '0;
  logic [NBTN-1:0] m_pb_meta = '0, m_pb_sync = '0, m_pb_samp = '0, m_pb_st = '0;
  logic [NBTN-1:0] m_pb_p1 = '0, m_pb_p2 = '0;
  logic [NBTN-1:0] m_evt = '0, m_mask = '0;
  logic            m_irq = 1'b0, m_dp_valid = 1'b0, m_write = 1'b0;
  logic [3:0]      m_addr = '0;
  logic [31:0]     exp_rdata = '0;
  int              m_edges = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [NBTN-1:0] set_v, clr_v;
    if (!HRESETn) begin
      m_sw_meta = '0; m_sw_sync = '0; m_sw_samp = '0; m_sw_st = '0;
      m_pb_meta = '0; m_pb_sync = '0; m_pb_samp = '0; m_pb_st = '0;
      m_pb_p1 = '0; m_pb_p2 = '0; m_evt = '0; m_mask = '0;
      m_irq = 1'b0; m_dp_valid = 1'b0; m_write = 1'b0; m_addr = '0;
      m_edges = 0;
    end else begin
      m_edges++;
      // A stable rise seen two edges ago sets the flag on this edge.
      set_v = m_pb_p1 & ~m_pb_p2;
      clr_v = (m_dp_valid && m_write && m_addr == 4'd2) ? HWDATA[NBTN-1:0] : '0;
      m_irq = |(m_evt & m_mask);
      m_evt = (m_evt & ~clr_v) | set_v;
      if (m_dp_valid && m_write && m_addr == 4'd3) m_mask = HWDATA[NBTN-1:0];
      m_pb_p2 = m_pb_p1;
      m_pb_p1 = m_pb_st;
      if (m_edges % D == 0) begin
        for (int i = 0; i < NSW; i++)
          if (m_sw_sync[i] == m_sw_samp[i]) m_sw_st[i] = m_sw_sync[i];
        for (int i = 0; i < NBTN; i++)
          if (m_pb_sync[i] == m_pb_samp[i]) m_pb_st[i] = m_pb_sync[i];
        m_sw_samp = m_sw_sync;
        m_pb_samp = m_pb_sync;
      end
      m_sw_sync = m_sw_meta; m_sw_meta = IO_SW;
      m_pb_sync = m_pb_meta; m_pb_meta = IO_PB;
      m_dp_valid = HSEL && HTRANS[1];
      if (m_dp_valid) begin
        m_addr  = HADDR;
        m_write = HWRITE;
      end
    end
    exp_rdata = '0;
    if (m_dp_valid && !m_write) begin
      case (m_addr)
        4'd0:    exp_rdata = 32'(m_sw_st);
        4'd1:    exp_rdata = 32'(m_pb_st);
        4'd2:    exp_rdata = 32'(m_evt);
        4'd3:    exp_rdata = 32'(m_mask);
        default: exp_rdata = '0;
      endcase
    end
  endtask

  initial begin
    forever begin
      @(posedge HCLK);
      model_step();
      #1;
      chk("cyc_hrdata", HRDATA, exp_rdata);
      chk("cyc_irq", 32'(IO_PB_IRQ), 32'(m_irq));
    end
  end

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = 1'b0;
    @(negedge HCLK);
    d = HRDATA;
    bus_idle();
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] v);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = 1'b1;
    @(negedge HCLK);
    HWDATA = v;
    bus_idle();
  endtask

  initial begin
    logic [31:0] rd;
    bit found;

    // Reset values, including a reset landing in a read data phase.
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 4'd0; HWRITE = 1'b0;
    @(negedge HCLK);
    bus_idle();
    HRESETn = 1'b0;
    #1 chk("rst_mid_read", HRDATA, 32'h0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_read(4'(i), rd);
      chk($sformatf("rst_read_%0d", i), rd, 32'h0);
    end
    chk("rst_irq", 32'(IO_PB_IRQ), 32'h0);
    @(negedge HCLK);
    chk("rst_idle_hrdata", HRDATA, 32'h0);

    // Switch read: too early returns 0, after settling returns the pins.
    @(negedge HCLK);
    IO_SW = 16'hA5C3;
    do_read(4'd0, rd);
    chk("sw_early", rd, 32'h0);
    repeat (12) @(negedge HCLK);
    do_read(4'd0, rd);
    chk("sw_settled", rd, 32'h0000A5C3);

    // Glitch shorter than one tick period never propagates.
    @(negedge HCLK);
    IO_PB = 5'b00100;
    repeat (3) @(negedge HCLK);
    IO_PB = 5'b00000;
    repeat (20) @(negedge HCLK);
    do_read(4'd1, rd);
    chk("glitch_pb", rd, 32'h0);
    do_read(4'd2, rd);
    chk("glitch_evt", rd, 32'h0);

    // Press, IRQ, write-0 no-op, write-1 clear.
    do_write(4'd3, 32'h04);
    @(negedge HCLK);
    IO_PB = 5'b00100;
    found = 1'b0;
    for (int i = 0; i < 2 * D + 6; i++) begin
      @(negedge HCLK);
      if (IO_PB_IRQ) begin
        found = 1'b1;
        break;
      end
    end
    chk("press_irq_rise", 32'(found), 32'h1);
    do_read(4'd2, rd);
    chk("press_evt", rd, 32'h04);
    do_write(4'd2, 32'h00);
    do_read(4'd2, rd);
    chk("w0_no_change", rd, 32'h04);
    do_write(4'd2, 32'h04);
    do_read(4'd2, rd);
    chk("w1c_evt", rd, 32'h0);
    chk("w1c_irq", 32'(IO_PB_IRQ), 32'h0);

    // Collision: W1C of bit 0 lands on the edge that sets bit 0.
    @(negedge HCLK);
    IO_PB = 5'b00101;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge HCLK);
      if (m_pb_st[0] && !m_pb_p1[0]) begin
        found = 1'b1;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 4'd2; HWRITE = 1'b1;
        @(negedge HCLK);
        HWDATA = 32'h1;
        bus_idle();
        break;
      end
    end
    chk("collision_timed", 32'(found), 32'h1);
    do_read(4'd2, rd);
    chk("collision_evt", rd, 32'h01);

    // Back-to-back pipeline: W mask, R mask, W idx0, R idx0, then IDLE.
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 4'd3; HWRITE = 1'b1;
    @(negedge HCLK);
    HWDATA = 32'h1F; HTRANS = 2'b11; HADDR = 4'd3; HWRITE = 1'b0;
    @(negedge HCLK);
    chk("b2b_mask", HRDATA, 32'h1F);
    HADDR = 4'd0; HWRITE = 1'b1;
    @(negedge HCLK);
    HWDATA = 32'hFFFF; HADDR = 4'd0; HWRITE = 1'b0;
    @(negedge HCLK);
    chk("b2b_sw", HRDATA, 32'h0000A5C3);
    HSEL = 1'b1; HTRANS = 2'b00;
    @(negedge HCLK);
    chk("b2b_idle", HRDATA, 32'h0);
    bus_idle();

    // Random traffic with one mid-run reset; the per-cycle model check covers it.
    for (int c = 0; c < 1200; c++) begin
      @(negedge HCLK);
      if (c == 600) HRESETn = 1'b0;
      if (c == 603) HRESETn = 1'b1;
      if ($urandom_range(0, 15) == 0) IO_SW = 16'($urandom);
      if ($urandom_range(0, 11) == 0) IO_PB = 5'($urandom);
      HSEL   = ($urandom_range(0, 3) != 0);
      HTRANS = 2'($urandom);
      HADDR  = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 4)) : 4'($urandom);
      HWRITE = 1'($urandom);
      HWDATA = $urandom;
    end
    @(negedge HCLK);
    bus_idle();
    repeat (5) @(negedge HCLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
